pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter INT_VECTOR, default 32'h0000_0010: interrupt service entry address.
REQ-003 Parameter DRAIN_CYCLES, default 3: fetch-hold cycles before interrupt entry (range 1..15).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 pc_cur  in  32  current PC register output.
REQ-007 stall  in  1  hazard-unit hold request.
REQ-008 inc2  in  1  current instruction is two words long; advance by 2.
REQ-009 redirect_valid / redirect_target  in  1 / 32  resolved branch or jump from EX.
REQ-010 ret_valid / ret_pc  in  1 / 32  return-from-interrupt with restored PC.
REQ-011 int_req  in  1  level-sensitive external interrupt request.
REQ-012 pc_we / pc_next  out  1 / 32  write enable and data to the PC register.
REQ-013 int_ack / epc  out  1 / 32  one-cycle interrupt acknowledge; saved return address.

Function
REQ-014 States SHALL be BOOT, RUN, DRAIN and ENTER.
REQ-015 BOOT: pc_we=1, pc_next=RESET_VECTOR for exactly one cycle, then RUN.
REQ-016 RUN priority SHALL be redirect_valid > ret_valid > interrupt start > stall > increment.
REQ-017 redirect_valid: pc_we=1, pc_next=redirect_target, even when stall=1.
REQ-018 ret_valid: pc_we=1, pc_next=ret_pc; in_isr clears on the same edge.
REQ-019 Interrupt start: int_req=1, in_isr=0 and no redirect/ret; pc_we=0; load counter with DRAIN_CYCLES; go to DRAIN.
REQ-020 stall alone: pc_we=0.
REQ-021 Increment: pc_we=1, pc_next=pc_cur+(inc2?2:1) modulo 2^32; 32'hFFFF_FFFF+1 wraps to 0.
REQ-022 DRAIN: pc_we=0 and counter decrements each cycle; at 1 go to ENTER.
REQ-023 In DRAIN, redirect_valid: pc_we=1, pc_next=redirect_target, and the counter reloads to DRAIN_CYCLES.
REQ-024 In DRAIN, stall and inc2 SHALL be ignored.
REQ-025 ENTER lasts one cycle: pc_we=1, pc_next=INT_VECTOR, int_ack=1, epc<=pc_cur, in_isr<=1, then RUN.
REQ-026 If int_req drops during DRAIN, entry SHALL still complete: an accepted request is committed.
REQ-027 While in_isr=1, int_req SHALL be ignored (no nesting).
REQ-028 If ret_valid and int_req coincide, the return is taken and the interrupt is evaluated from the next cycle.
REQ-029 Outputs pc_we, pc_next and int_ack SHALL be combinational from state and inputs; epc SHALL be registered.

Reset
REQ-030 While rst=1: pc_we=0, pc_next=RESET_VECTOR, int_ack=0, epc=0, in_isr=0, counter=0, state<=BOOT.
REQ-031 rst asserted mid-DRAIN or mid-ENTER SHALL abort the interrupt; no int_ack is issued.

Configuration
REQ-032 Macro PC_SEQUENCER_INT_EN defined: interrupt logic (DRAIN, ENTER, in_isr, epc) is present as specified.
REQ-033 Macro PC_SEQUENCER_INT_EN undefined: int_req is ignored, int_ack=0, epc=0, and the FSM has only BOOT and RUN.
REQ-034 ret_valid behaviour is unchanged in either configuration.

Structure
REQ-035 Package pc_seq_pkg SHALL hold the state enum, PC_W=32, and default RESET_VECTOR and INT_VECTOR constants.
REQ-036 Sub-module pc_seq_irq SHALL hold the drain counter, in_isr and epc; it is instantiated only under PC_SEQUENCER_INT_EN.

Verification
REQ-037 Release rst with pc_cur=0 -> one cycle pc_we=1, pc_next=0; then with inc2=0, pc_next=1.
REQ-038 pc_cur=100, inc2=1 -> pc_next=102; pc_cur=32'hFFFF_FFFF, inc2=0 -> pc_next=0.
REQ-039 stall=1 and redirect_valid=1, target 500 -> pc_we=1, pc_next=500; stall alone -> pc_we=0.
REQ-040 int_req=1 at pc_cur=40, DRAIN_CYCLES=3 -> 3 cycles pc_we=0, then int_ack=1, pc_next=16, epc=40; a second int_req is ignored until ret_valid, ret_pc=40 -> pc_next=40.
REQ-041 redirect to 900 in the 2nd DRAIN cycle -> drain restarts (3 cycles), then epc=900.
REQ-042 rst during DRAIN -> int_ack never asserts; next cycle is BOOT with pc_next=RESET_VECTOR.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared types and constants for the PC sequencer slice: PC width, drain
// counter width, default reset/interrupt vectors, the sequencer state enum
// and the sequential PC advance helper.
// Ports: none (package).
package pc_seq_pkg;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEF_INT_VECTOR   = 32'h0000_0010;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        ENTER = 2'd3
    } pc_state_e;

    // pc + 1 or pc + 2, wrapping modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                   input logic            inc2);
        return pc + {{(PC_W-2){1'b0}}, inc2, ~inc2};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the fetch-side signals between the pipeline and the PC sequencer.
//   master : pipeline side (drives pc_cur, stall, inc2, redirect, ret, int_req)
//   slave  : sequencer side (drives pc_we, pc_next, int_ack, epc)
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic [PC_W-1:0] pc_cur;
    logic            stall;
    logic            inc2;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    logic            ret_valid;
    logic [PC_W-1:0] ret_pc;
    logic            int_req;
    logic            pc_we;
    logic [PC_W-1:0] pc_next;
    logic            int_ack;
    logic [PC_W-1:0] epc;

    modport master (
        output pc_cur, stall, inc2, redirect_valid, redirect_target,
               ret_valid, ret_pc, int_req,
        input  pc_we, pc_next, int_ack, epc
    );

    modport slave (
        input  pc_cur, stall, inc2, redirect_valid, redirect_target,
               ret_valid, ret_pc, int_req,
        output pc_we, pc_next, int_ack, epc
    );

endinterface

// File: rtl/pc_seq_irq.sv
// pc_seq_irq
// Interrupt bookkeeping for the PC sequencer: drain hold-off counter,
// in-service flag and the saved return address. Only instantiated when
// PC_SEQUENCER_INT_EN is defined.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         reload the drain counter with DRAIN_CYCLES
//   dec          decrement the drain counter
//   enter        interrupt entry: capture pc_cur into epc, set in_isr
//   ret          return from interrupt: clear in_isr
//   pc_cur       current PC (captured on entry)
//   cnt_last     drain counter is at its final cycle
//   in_isr       an interrupt is being serviced
//   epc          saved return address
module pc_seq_irq
    import pc_seq_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            dec,
    input  logic            enter,
    input  logic            ret,
    input  logic [PC_W-1:0] pc_cur,
    output logic            cnt_last,
    output logic            in_isr,
    output logic [PC_W-1:0] epc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            in_isr <= 1'b0;
            epc    <= '0;
        end else begin
            if (load) begin
                cnt <= CNT_W'(DRAIN_CYCLES);
            end else if (dec) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (enter) begin
                in_isr <= 1'b1;
                epc    <= pc_cur;
            end else if (ret) begin
                in_isr <= 1'b0;
            end
        end
    end

    assign cnt_last = (cnt == CNT_W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Chooses the next fetch address each cycle: boot vector after reset, branch
// redirect, interrupt return, interrupt entry (after a drain hold-off), stall
// hold, or sequential advance by one or two words.
// Configuration: PC_SEQUENCER_INT_EN enables interrupt support (DRAIN/ENTER
// states, in_isr, epc). Without it int_req is ignored, int_ack=0 and epc=0.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       pc_sequencer_if.slave (pipeline inputs, PC write outputs)
//
// state | meaning
// ------+------------------------------------------------------------
// BOOT  | write RESET_VECTOR into the PC for one cycle
// RUN   | normal fetch: redirect > ret > interrupt start > stall > advance
// DRAIN | interrupt accepted, fetch held while the pipeline empties
// ENTER | one cycle: jump to INT_VECTOR, ack, save return address
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [PC_W-1:0] INT_VECTOR   = DEF_INT_VECTOR,
    parameter int unsigned     DRAIN_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    pc_state_e       state, state_next;
    logic            pc_we;
    logic [PC_W-1:0] pc_next;
    logic            int_ack;
    logic            irq_load, irq_dec, irq_enter, irq_ret;

`ifdef PC_SEQUENCER_INT_EN
    logic            cnt_last;
    logic            in_isr;
    logic [PC_W-1:0] epc;

    pc_seq_irq #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_irq (
        .clk      (clk),
        .rst      (rst),
        .load     (irq_load),
        .dec      (irq_dec),
        .enter    (irq_enter),
        .ret      (irq_ret),
        .pc_cur   (bus.pc_cur),
        .cnt_last (cnt_last),
        .in_isr   (in_isr),
        .epc      (epc)
    );

    assign bus.epc = epc;
`else
    assign bus.epc = '0;

    logic unused_irq;
    assign unused_irq = ^{irq_load, irq_dec, irq_enter, irq_ret,
                          bus.int_req, INT_VECTOR, 4'(DRAIN_CYCLES)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_we      = 1'b0;
        pc_next    = bus.pc_cur;
        int_ack    = 1'b0;
        irq_load   = 1'b0;
        irq_dec    = 1'b0;
        irq_enter  = 1'b0;
        irq_ret    = 1'b0;

        if (rst) begin
            pc_next    = RESET_VECTOR;
            state_next = BOOT;
        end else begin
            case (state)
                BOOT: begin
                    pc_we      = 1'b1;
                    pc_next    = RESET_VECTOR;
                    state_next = RUN;
                end
                RUN: begin
                    if (bus.redirect_valid) begin
                        pc_we   = 1'b1;
                        pc_next = bus.redirect_target;
                    end else if (bus.ret_valid) begin
                        pc_we   = 1'b1;
                        pc_next = bus.ret_pc;
                        irq_ret = 1'b1;
`ifdef PC_SEQUENCER_INT_EN
                    end else if (bus.int_req && !in_isr) begin
                        irq_load   = 1'b1;
                        state_next = DRAIN;
`endif
                    end else if (bus.stall) begin
                        pc_we = 1'b0;
                    end else begin
                        pc_we   = 1'b1;
                        pc_next = pc_advance(bus.pc_cur, bus.inc2);
                    end
                end
`ifdef PC_SEQUENCER_INT_EN
                DRAIN: begin
                    // A redirect still lands in the PC, but the wrong-path
                    // fetches it triggers must drain again before entry.
                    if (bus.redirect_valid) begin
                        pc_we    = 1'b1;
                        pc_next  = bus.redirect_target;
                        irq_load = 1'b1;
                    end else begin
                        irq_dec = 1'b1;
                        if (cnt_last) begin
                            state_next = ENTER;
                        end
                    end
                end
                ENTER: begin
                    pc_we      = 1'b1;
                    pc_next    = INT_VECTOR;
                    int_ack    = 1'b1;
                    irq_enter  = 1'b1;
                    state_next = RUN;
                end
`endif
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    assign bus.pc_we   = pc_we;
    assign bus.pc_next = pc_next;
    assign bus.int_ack = int_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: a behavioural model of the fetch
// address rules is checked against the DUT on every cycle, with directed
// literal expectations followed by randomized stimulus. Adapts to the
// PC_SEQUENCER_INT_EN build option.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] IV = 32'h0000_0010;
    localparam int          D  = 3;
`ifdef PC_SEQUENCER_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .INT_VECTOR   (IV),
        .DRAIN_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] pc_reg = 32'h0;
    assign bus.pc_cur = pc_reg;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // expected outputs for the current cycle
    logic        e_we, e_ack;
    logic [31:0] e_next;

    // model state: pending boot write, remaining hold cycles of an accepted
    // interrupt, entry due this cycle, servicing flag, saved address
    bit          m_boot  = 1'b1;
    int          m_hold  = 0;
    bit          m_enter = 1'b0;
    bit          m_isr   = 1'b0;
    logic [31:0] m_epc   = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compute_exp();
        e_we   = 1'b0;
        e_ack  = 1'b0;
        e_next = pc_reg;
        if (rst) begin
            e_next = RV;
        end else if (m_boot) begin
            e_we = 1'b1; e_next = RV;
        end else if (m_enter) begin
            e_we = 1'b1; e_next = IV; e_ack = 1'b1;
        end else if (m_hold > 0) begin
            if (bus.redirect_valid) begin
                e_we = 1'b1; e_next = bus.redirect_target;
            end
        end else if (bus.redirect_valid) begin
            e_we = 1'b1; e_next = bus.redirect_target;
        end else if (bus.ret_valid) begin
            e_we = 1'b1; e_next = bus.ret_pc;
        end else if (INT_EN && bus.int_req && !m_isr) begin
            e_we = 1'b0;
        end else if (!bus.stall) begin
            e_we = 1'b1; e_next = pc_reg + (bus.inc2 ? 32'd2 : 32'd1);
        end
    endtask

    task automatic advance();
        if (rst) begin
            m_boot = 1'b1; m_hold = 0; m_enter = 1'b0; m_isr = 1'b0; m_epc = 32'h0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_enter) begin
            m_enter = 1'b0; m_isr = 1'b1; m_epc = pc_reg;
        end else if (m_hold > 0) begin
            if (bus.redirect_valid) m_hold = D;
            else if (m_hold == 1) begin m_hold = 0; m_enter = 1'b1; end
            else m_hold = m_hold - 1;
        end else if (!bus.redirect_valid) begin
            if (bus.ret_valid) m_isr = 1'b0;
            else if (INT_EN && bus.int_req && !m_isr) m_hold = D;
        end
        if (e_we) pc_reg = e_next;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_we", 32'(bus.pc_we), 32'(e_we));
            chk("int_ack", 32'(bus.int_ack), 32'(e_ack));
            chk("epc", bus.epc, m_epc);
            if (e_we || rst) chk("pc_next", bus.pc_next, e_next);
        end
    end

    task automatic half();
        compute_exp();
        @(negedge clk);
        #1;
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic cycle();
        half();
        fin();
    endtask

    initial begin
        bus.stall = 1'b0; bus.inc2 = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
        bus.ret_valid = 1'b0; bus.ret_pc = 32'h0; bus.int_req = 1'b0;

        cycle();
        chk_en = 1'b1;
        half();
        chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
        chk("rst_pc_next", bus.pc_next, 32'h0);
        chk("rst_int_ack", 32'(bus.int_ack), 32'd0);
        chk("rst_epc", bus.epc, 32'h0);
        fin();

        rst = 1'b0;
        half();
        chk("boot_we", 32'(bus.pc_we), 32'd1);
        chk("boot_next", bus.pc_next, 32'h0);
        fin();
        half(); chk("inc1", bus.pc_next, 32'd1); fin();

        pc_reg = 32'd100; bus.inc2 = 1'b1;
        half(); chk("inc2_102", bus.pc_next, 32'd102); fin();
        bus.inc2 = 1'b0; pc_reg = 32'hFFFF_FFFF;
        half(); chk("wrap", bus.pc_next, 32'h0); chk("wrap_we", 32'(bus.pc_we), 32'd1); fin();

        bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'd500;
        half(); chk("redir_stall_we", 32'(bus.pc_we), 32'd1); chk("redir_500", bus.pc_next, 32'd500); fin();
        bus.redirect_valid = 1'b0;
        half(); chk("stall_we", 32'(bus.pc_we), 32'd0); fin();
        bus.stall = 1'b0;

`ifdef PC_SEQUENCER_INT_EN
        pc_reg = 32'd40; bus.int_req = 1'b1;
        half(); chk("int_start_we", 32'(bus.pc_we), 32'd0); fin();
        bus.int_req = 1'b0;
        for (int i = 0; i < D; i++) begin
            half(); chk("drain_we", 32'(bus.pc_we), 32'd0); chk("drain_ack", 32'(bus.int_ack), 32'd0); fin();
        end
        half(); chk("enter_ack", 32'(bus.int_ack), 32'd1); chk("enter_next", bus.pc_next, 32'd16); fin();
        bus.int_req = 1'b1;
        half(); chk("epc_40", bus.epc, 32'd40); chk("nest_ignored", bus.pc_next, 32'd17); fin();
        half(); chk("nest_ignored_we", 32'(bus.pc_we), 32'd1); fin();
        bus.ret_valid = 1'b1; bus.ret_pc = 32'd40;
        half(); chk("ret_40", bus.pc_next, 32'd40); chk("ret_we", 32'(bus.pc_we), 32'd1); fin();
        bus.ret_valid = 1'b0;
        half(); chk("int_after_ret", 32'(bus.pc_we), 32'd0); fin();
        bus.int_req = 1'b0;
        cycle();
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'd900;
        half(); chk("drain_redir", bus.pc_next, 32'd900); fin();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < D; i++) begin
            half(); chk("redrain_ack", 32'(bus.int_ack), 32'd0); chk("redrain_we", 32'(bus.pc_we), 32'd0); fin();
        end
        half(); chk("enter2_ack", 32'(bus.int_ack), 32'd1); fin();
        half(); chk("epc_900", bus.epc, 32'd900); fin();
        bus.ret_valid = 1'b1; bus.ret_pc = 32'd900;
        cycle();
        bus.ret_valid = 1'b0; bus.int_req = 1'b1;
        cycle();
        bus.int_req = 1'b0;
        cycle();
        rst = 1'b1;
        half(); chk("rst_drain_ack", 32'(bus.int_ack), 32'd0); chk("rst_drain_next", bus.pc_next, RV); fin();
        rst = 1'b0;
        half(); chk("reboot_next", bus.pc_next, RV); chk("reboot_we", 32'(bus.pc_we), 32'd1); fin();
        for (int i = 0; i < D + 2; i++) begin
            half(); chk("no_ack_after_rst", 32'(bus.int_ack), 32'd0); fin();
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.inc2 = 1'($urandom_range(0, 1));
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            bus.redirect_target = $urandom;
            bus.ret_valid = ($urandom_range(0, 11) == 0);
            bus.ret_pc = $urandom;
            bus.int_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) pc_reg = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
